// File: rtl/rr_dispatch.sv
// rr_dispatch: routes one upstream beat per cycle into one of NumOut
// single-entry output slots. The target slot comes either from idx_i
// (ExtIdx=1) or from an internal round-robin pointer (ExtIdx=0).
// Each slot drives its valid_o/data_o bit straight from flops.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset (clears slot valids and pointer)
//   flush_i  - synchronous clear of the round-robin pointer only
//   valid_i  - upstream beat valid
//   ready_o  - upstream beat accepted when valid_i & ready_o
//   data_i   - upstream payload
//   idx_i    - explicit target slot (ExtIdx=1 only)
//   valid_o  - per-output beat valid
//   ready_i  - per-output downstream ready
//   data_o   - per-output payload
//   sel_o    - target of the beat accepted this cycle
module rr_dispatch #(
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32,
    parameter bit          ExtIdx    = 1'b0,
    localparam int unsigned IdxWidth = $clog2(NumOut)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [DataWidth-1:0]               data_i,
    input  logic [IdxWidth-1:0]                idx_i,
    output logic [NumOut-1:0]                  valid_o,
    input  logic [NumOut-1:0]                  ready_i,
    output logic [NumOut-1:0][DataWidth-1:0]   data_o,
    output logic [IdxWidth-1:0]                sel_o
);

    logic [NumOut-1:0]                r_valid;
    logic [NumOut-1:0][DataWidth-1:0] r_data;
    logic [IdxWidth-1:0]              r_rr;

    logic [NumOut-1:0]   w_avail;
    logic                w_found;
    logic [IdxWidth-1:0] w_tgt;
    logic                w_in_range;
    logic [IdxWidth-1:0] w_sel;
    logic                w_accept;
    logic [IdxWidth-1:0] w_rr_next;

    // A slot can take a beat if it is empty or is being drained this cycle.
    assign w_avail = ~r_valid | ready_i;

    // Round-robin search: walk slots starting at r_rr, wrapping modulo NumOut,
    // and take the first available one.
    always_comb begin
        int unsigned v_c;
        w_found = 1'b0;
        w_tgt   = '0;
        v_c     = 0;
        for (int unsigned i = 0; i < NumOut; i++) begin
            v_c = (32'(r_rr) + i) % NumOut;
            if (!w_found && w_avail[v_c]) begin
                w_found = 1'b1;
                w_tgt   = IdxWidth'(v_c);
            end
        end
    end

    assign w_in_range = (32'(idx_i) < NumOut);

    always_comb begin
        if (ExtIdx) begin
            // Only the addressed slot matters; no bypass to other free slots.
            ready_o = w_in_range & w_avail[idx_i];
            w_sel   = idx_i;
        end else begin
            ready_o = w_found;
            w_sel   = w_tgt;
        end
    end

    assign sel_o     = w_sel;
    assign w_accept  = valid_i & ready_o;
    assign w_rr_next = (32'(w_tgt) == NumOut - 1) ? '0 : w_tgt + IdxWidth'(1);

    // Control state: reset beats flush, flush beats the accept's pointer update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_rr    <= '0;
        end else begin
            for (int unsigned k = 0; k < NumOut; k++) begin
                if (w_accept && (32'(w_sel) == k)) begin
                    r_valid[k] <= 1'b1;
                end else if (ready_i[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            if (flush_i) begin
                r_rr <= '0;
            end else if (w_accept && !ExtIdx) begin
                r_rr <= w_rr_next;
            end
        end
    end

    // Payload flops carry no reset; valid qualifies them.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NumOut; k++) begin
            if (w_accept && (32'(w_sel) == k)) begin
                r_data[k] <= data_i;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;

endmodule

// File: tb/tb_rr_dispatch.sv
// tb_rr_dispatch: directed bench for rr_dispatch with a round-robin instance
// (u_rr, ExtIdx=0) and an explicit-index instance (u_ext, ExtIdx=1), both
// NumOut=4, DataWidth=8. A slot-level model checks every cycle; directed
// steps add literal expectations.
module tb_rr_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic            a_flush, a_valid, a_ready_o;
    logic [7:0]      a_data;
    logic [1:0]      a_idx, a_sel;
    logic [3:0]      a_valid_o, a_ready_i;
    logic [3:0][7:0] a_data_o;

    logic            b_flush, b_valid, b_ready_o;
    logic [7:0]      b_data;
    logic [1:0]      b_idx, b_sel;
    logic [3:0]      b_valid_o, b_ready_i;
    logic [3:0][7:0] b_data_o;

    rr_dispatch #(.NumOut(4), .DataWidth(8), .ExtIdx(1'b0)) u_rr (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .valid_i(a_valid),
        .ready_o(a_ready_o), .data_i(a_data), .idx_i(a_idx),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .sel_o(a_sel)
    );

    rr_dispatch #(.NumOut(4), .DataWidth(8), .ExtIdx(1'b1)) u_ext (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .valid_i(b_valid),
        .ready_o(b_ready_o), .data_i(b_data), .idx_i(b_idx),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .sel_o(b_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: per unit, four slots (valid/data) and a round-robin pointer.
    logic [3:0] m_valid [2];
    logic [7:0] m_data  [2][4];
    int         m_rr    [2];
    bit         m_known [2];

    task automatic model_step(input int u, input bit ext, input logic r, input logic flush,
                              input logic vld, input logic [7:0] din, input logic [1:0] idx,
                              input logic [3:0] rdy, input logic d_ready, input logic [1:0] d_sel,
                              input logic [3:0] d_valid, input logic [3:0][7:0] d_data);
        int tgt;
        int c;
        bit er;
        if (m_known[u]) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("u%0d valid_o[%0d]", u, k), 32'(d_valid[k]), 32'(m_valid[u][k]));
                if (m_valid[u][k])
                    chk($sformatf("u%0d data_o[%0d]", u, k), 32'(d_data[k]), 32'(m_data[u][k]));
            end
            tgt = -1;
            if (ext) begin
                if (!m_valid[u][idx] || rdy[idx]) tgt = int'(idx);
            end else begin
                for (int off = 0; off < 4; off++) begin
                    c = (m_rr[u] + off) % 4;
                    if (tgt < 0 && (!m_valid[u][c] || rdy[c])) tgt = c;
                end
            end
            er = (tgt >= 0);
            chk($sformatf("u%0d ready_o", u), 32'(d_ready), 32'(er));
            if (vld && er) chk($sformatf("u%0d sel_o", u), 32'(d_sel), 32'(tgt));
            if (!r) begin
                for (int k = 0; k < 4; k++)
                    if (m_valid[u][k] && rdy[k]) m_valid[u][k] = 1'b0;
                if (vld && er) begin
                    m_valid[u][tgt] = 1'b1;
                    m_data[u][tgt]  = din;
                    if (!ext) m_rr[u] = (tgt + 1) % 4;
                end
                if (flush) m_rr[u] = 0;
            end
        end
        if (r) begin
            m_valid[u] = '0;
            m_rr[u]    = 0;
            m_known[u] = 1'b1;
        end
    endtask

    // Inputs change just after posedge; negedge sees settled values that the
    // next posedge will sample.
    always @(negedge clk) begin
        model_step(0, 1'b0, rst, a_flush, a_valid, a_data, a_idx, a_ready_i,
                   a_ready_o, a_sel, a_valid_o, a_data_o);
        model_step(1, 1'b1, rst, b_flush, b_valid, b_data, b_idx, b_ready_i,
                   b_ready_o, b_sel, b_valid_o, b_data_o);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_known[0] = 1'b0;
        m_known[1] = 1'b0;
        rst = 1'b1;
        a_flush = 0; a_valid = 0; a_data = '0; a_idx = '0; a_ready_i = '0;
        b_flush = 0; b_valid = 0; b_data = '0; b_idx = '0; b_ready_i = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset valid_o rr", 32'(a_valid_o), 32'h0);
        chk("reset valid_o ext", 32'(b_valid_o), 32'h0);

        // Streaming with all outputs ready: 0,1,2,3,0.
        a_ready_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(8'h10 + i);
            #1;
            chk("stream sel", 32'(a_sel), 32'(i % 4));
            step();
            chk("stream valid_o", 32'(a_valid_o), 32'(1 << (i % 4)));
            chk("stream data", 32'(a_data_o[i % 4]), 32'(8'h10 + i));
        end
        a_valid = 1'b0;
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        chk("drained", 32'(a_valid_o), 32'h0);
        chk("model rr after flush", 32'(m_rr[0]), 32'd0);

        // Backpressure: fill all four, fifth blocked, then slot 2 drains and refills.
        a_ready_i = 4'h0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(8'h20 + i);
            step();
        end
        chk("full valid_o", 32'(a_valid_o), 32'hF);
        a_data = 8'h24;
        #1;
        chk("full ready_o", 32'(a_ready_o), 32'h0);
        step();
        chk("blocked data2", 32'(a_data_o[2]), 32'h22);
        a_ready_i = 4'b0100;
        #1;
        chk("refill ready_o", 32'(a_ready_o), 32'h1);
        chk("refill sel", 32'(a_sel), 32'h2);
        step();
        chk("refill valid_o", 32'(a_valid_o), 32'hF);
        chk("refill data2", 32'(a_data_o[2]), 32'h24);
        chk("held data0", 32'(a_data_o[0]), 32'h20);
        a_valid = 1'b0;
        a_ready_i = 4'hF;
        step();
        chk("all drained", 32'(a_valid_o), 32'h0);

        // Flush with a simultaneous accept at rr=2.
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        a_valid = 1'b1;
        a_data = 8'h30; step();
        a_data = 8'h31; step();
        chk("model rr before flush", 32'(m_rr[0]), 32'd2);
        a_flush = 1'b1;
        a_data  = 8'h32;
        #1;
        chk("flush accept sel", 32'(a_sel), 32'h2);
        step();
        chk("flush valid_o", 32'(a_valid_o), 32'b0100);
        chk("flush data2", 32'(a_data_o[2]), 32'h32);
        a_flush = 1'b0;
        a_data  = 8'h33;
        #1;
        chk("post-flush sel", 32'(a_sel), 32'h0);
        step();
        chk("post-flush valid_o", 32'(a_valid_o), 32'b0001);
        chk("post-flush data0", 32'(a_data_o[0]), 32'h33);

        // Reset with slots 0,1 full and a beat accepted in the reset cycle.
        a_valid = 1'b0;
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        a_ready_i = 4'h0;
        a_valid = 1'b1;
        a_data = 8'h40; step();
        a_data = 8'h41; step();
        chk("pre-reset valid_o", 32'(a_valid_o), 32'b0011);
        rst = 1'b1;
        a_data = 8'h42;
        step();
        rst = 1'b0;
        chk("post-reset valid_o", 32'(a_valid_o), 32'h0);
        a_ready_i = 4'hF;
        a_data = 8'h43;
        #1;
        chk("post-reset sel", 32'(a_sel), 32'h0);
        step();
        chk("post-reset first valid_o", 32'(a_valid_o), 32'b0001);
        chk("post-reset first data", 32'(a_data_o[0]), 32'h43);
        a_valid = 1'b0;
        step();

        // Explicit index: blocked slot 1 must not bypass to free slots.
        b_ready_i = 4'h0;
        b_idx = 2'd1;
        b_valid = 1'b1;
        b_data = 8'hAA;
        #1;
        chk("ext sel", 32'(b_sel), 32'h1);
        step();
        chk("ext valid_o", 32'(b_valid_o), 32'b0010);
        b_data = 8'hBB;
        #1;
        chk("ext hol ready_o", 32'(b_ready_o), 32'h0);
        step();
        chk("ext hol data1", 32'(b_data_o[1]), 32'hAA);
        chk("ext hol valid_o", 32'(b_valid_o), 32'b0010);

        // Explicit index: reload slot 3 in the same cycle it drains.
        b_idx = 2'd3;
        b_data = 8'h77;
        step();
        chk("ext slot3 valid_o", 32'(b_valid_o), 32'b1010);
        b_ready_i = 4'b1000;
        b_data = 8'h55;
        #1;
        chk("ext reload ready_o", 32'(b_ready_o), 32'h1);
        step();
        chk("ext reload valid_o", 32'(b_valid_o), 32'b1010);
        chk("ext reload data3", 32'(b_data_o[3]), 32'h55);
        b_valid = 1'b0;
        b_ready_i = 4'hF;
        step();
        chk("ext drained", 32'(b_valid_o), 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
